// File: rtl/ram_bridge16.sv
// ram_bridge16: runs single-cycle RAM requests on a 16-bit SRAM-style bus with programmable wait states.
// Optional RAM_BRIDGE_ROTATE_EN: misaligned word reads return the aligned word rotated right by 8*addr[1:0].
module ram_bridge16 #(
    parameter int WAIT_STATES = 1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        i_ram_en,
    input  logic        i_ram_wr,
    input  logic [1:0]  i_ram_size,
    input  logic [31:0] i_ram_addr,
    input  logic [31:0] i_ram_wdata,
    output logic [31:0] o_ram_rdata,
    output logic        o_ram_stall,
    output logic        o_ext_cs,
    output logic        o_ext_we,
    output logic [1:0]  o_ext_be,
    output logic [30:0] o_ext_addr,
    output logic [15:0] o_ext_wdata,
    input  logic [15:0] i_ext_rdata
);

    localparam logic [1:0] MEM_B   = 2'b00;
    localparam logic [1:0] MEM_H   = 2'b01;
    localparam logic [3:0] WS_LOAD = 4'(WAIT_STATES);

`ifdef RAM_BRIDGE_ROTATE_EN
    localparam int ALO_W = 2;
`else
    localparam int ALO_W = 1;
`endif

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        BEAT0 = 2'd1,
        BEAT1 = 2'd2,
        DONE  = 2'd3
    } state_t;

    state_t            state_q, state_d;
    logic [3:0]        cnt_q, cnt_d;
    logic              cs_q, cs_d;
    logic              we_q, we_d;
    logic [1:0]        be_q, be_d;
    logic [30:0]       eaddr_q, eaddr_d;
    logic [15:0]       ewdata_q, ewdata_d;
    logic [31:0]       rdata_q, rdata_d;

    // Request fields latched at accept; only the parts needed after beat 0 are kept.
    logic              wr_q, wr_d;
    logic [1:0]        size_q, size_d;
    logic [ALO_W-1:0]  alo_q, alo_d;
    logic [15:0]       whi_q, whi_d;
    logic [15:0]       rlo_q, rlo_d;

    logic [31:0]       word_rd;
    logic [31:0]       fin_rdata;
    logic              stall;

    function automatic logic [1:0] lane_be(input logic [1:0] size, input logic a0);
        if (size == MEM_B) begin
            return a0 ? 2'b10 : 2'b01;
        end
        return 2'b11;
    endfunction

    function automatic logic [15:0] lane_wdata(input logic [1:0] size, input logic [15:0] wd);
        if (size == MEM_B) begin
            return {wd[7:0], wd[7:0]};
        end
        return wd;
    endfunction

    function automatic logic [30:0] first_haddr(input logic [1:0] size, input logic [31:0] addr);
        if (size[1]) begin
            return {addr[31:2], 1'b0};
        end
        return addr[31:1];
    endfunction

`ifdef RAM_BRIDGE_ROTATE_EN
    function automatic logic [31:0] rotr_bytes(input logic [31:0] w, input logic [1:0] sh);
        case (sh)
            2'd0:    return w;
            2'd1:    return {w[7:0],  w[31:8]};
            2'd2:    return {w[15:0], w[31:16]};
            default: return {w[23:0], w[31:24]};
        endcase
    endfunction
`endif

    // Read result assembled from the beat that is completing this cycle.
    always_comb begin
`ifdef RAM_BRIDGE_ROTATE_EN
        word_rd = rotr_bytes({i_ext_rdata, rlo_q}, alo_q);
`else
        word_rd = {i_ext_rdata, rlo_q};
`endif
        case (size_q)
            MEM_B:   fin_rdata = {24'b0, alo_q[0] ? i_ext_rdata[15:8] : i_ext_rdata[7:0]};
            MEM_H:   fin_rdata = {16'b0, i_ext_rdata};
            default: fin_rdata = word_rd;
        endcase
    end

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        cs_d     = cs_q;
        we_d     = we_q;
        be_d     = be_q;
        eaddr_d  = eaddr_q;
        ewdata_d = ewdata_q;
        rdata_d  = rdata_q;
        wr_d     = wr_q;
        size_d   = size_q;
        alo_d    = alo_q;
        whi_d    = whi_q;
        rlo_d    = rlo_q;
        stall    = 1'b0;

        case (state_q)
            IDLE: begin
                stall = i_ram_en;
                if (i_ram_en) begin
                    wr_d     = i_ram_wr;
                    size_d   = i_ram_size;
                    alo_d    = i_ram_addr[ALO_W-1:0];
                    whi_d    = i_ram_wdata[31:16];
                    cs_d     = 1'b1;
                    we_d     = i_ram_wr;
                    be_d     = lane_be(i_ram_size, i_ram_addr[0]);
                    eaddr_d  = first_haddr(i_ram_size, i_ram_addr);
                    ewdata_d = lane_wdata(i_ram_size, i_ram_wdata[15:0]);
                    cnt_d    = WS_LOAD;
                    state_d  = BEAT0;
                end
            end
            BEAT0, BEAT1: begin
                stall = 1'b1;
                if (cnt_q != 4'd0) begin
                    cnt_d = cnt_q - 4'd1;
                end else if (state_q == BEAT0 && size_q[1]) begin
                    // Low half of a word is done; the upper half follows on the next halfword.
                    if (!wr_q) begin
                        rlo_d = i_ext_rdata;
                    end
                    eaddr_d  = eaddr_q + 31'd1;
                    ewdata_d = whi_q;
                    be_d     = 2'b11;
                    cnt_d    = WS_LOAD;
                    state_d  = BEAT1;
                end else begin
                    if (!wr_q) begin
                        rdata_d = fin_rdata;
                    end
                    cs_d    = 1'b0;
                    we_d    = 1'b0;
                    be_d    = 2'b00;
                    state_d = DONE;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= IDLE;
            cnt_q    <= 4'd0;
            cs_q     <= 1'b0;
            we_q     <= 1'b0;
            be_q     <= 2'b00;
            eaddr_q  <= '0;
            ewdata_q <= '0;
            rdata_q  <= '0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            cs_q     <= cs_d;
            we_q     <= we_d;
            be_q     <= be_d;
            eaddr_q  <= eaddr_d;
            ewdata_q <= ewdata_d;
            rdata_q  <= rdata_d;
        end
    end

    // Latched request fields are only meaningful inside an access, so they carry no reset.
    always_ff @(posedge clk) begin
        wr_q   <= wr_d;
        size_q <= size_d;
        alo_q  <= alo_d;
        whi_q  <= whi_d;
        rlo_q  <= rlo_d;
    end

    assign o_ram_stall = stall;
    assign o_ram_rdata = rdata_q;
    assign o_ext_cs    = cs_q;
    assign o_ext_we    = we_q;
    assign o_ext_be    = be_q;
    assign o_ext_addr  = eaddr_q;
    assign o_ext_wdata = ewdata_q;

endmodule

// File: tb/tb_ram_bridge16.sv
// tb_ram_bridge16: directed vector table plus randomized accesses against a byte-level memory model,
// on two bridge instances (WAIT_STATES=0 and WAIT_STATES=1).
module tb_ram_bridge16;

    localparam logic [1:0] MB = 2'b00;
    localparam logic [1:0] MH = 2'b01;
    localparam logic [1:0] MW = 2'b10;
`ifdef RAM_BRIDGE_ROTATE_EN
    localparam bit ROT = 1'b1;
`else
    localparam bit ROT = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst;
    logic        en    [2];
    logic        wr    [2];
    logic [1:0]  size  [2];
    logic [31:0] addr  [2];
    logic [31:0] wdata [2];
    logic [31:0] rdata [2];
    logic        stall [2];
    logic        cs    [2];
    logic        we    [2];
    logic [1:0]  be    [2];
    logic [30:0] xaddr [2];
    logic [15:0] xwd   [2];
    logic [15:0] xrd   [2];

    always #5 clk = ~clk;

    ram_bridge16 #(.WAIT_STATES(0)) u_dut0 (
        .clk(clk), .rst(rst),
        .i_ram_en(en[0]), .i_ram_wr(wr[0]), .i_ram_size(size[0]), .i_ram_addr(addr[0]),
        .i_ram_wdata(wdata[0]), .o_ram_rdata(rdata[0]), .o_ram_stall(stall[0]),
        .o_ext_cs(cs[0]), .o_ext_we(we[0]), .o_ext_be(be[0]), .o_ext_addr(xaddr[0]),
        .o_ext_wdata(xwd[0]), .i_ext_rdata(xrd[0])
    );

    ram_bridge16 #(.WAIT_STATES(1)) u_dut1 (
        .clk(clk), .rst(rst),
        .i_ram_en(en[1]), .i_ram_wr(wr[1]), .i_ram_size(size[1]), .i_ram_addr(addr[1]),
        .i_ram_wdata(wdata[1]), .o_ram_rdata(rdata[1]), .o_ram_stall(stall[1]),
        .o_ext_cs(cs[1]), .o_ext_we(we[1]), .o_ext_be(be[1]), .o_ext_addr(xaddr[1]),
        .o_ext_wdata(xwd[1]), .i_ext_rdata(xrd[1])
    );

    // External SRAM: 1024 halfwords per instance, indexed by the low halfword-address bits.
    logic [15:0] xmem [2][1024];
    logic        pk_en;
    int          pk_k, pk_i;
    logic [15:0] pk_v;

    function automatic logic [15:0] pat(input int k, input int i);
        return 16'(i * 40503 + k * 7919 + 1);
    endfunction

    always @(posedge clk) begin
        if (rst) begin
            for (int mk = 0; mk < 2; mk++)
                for (int mi = 0; mi < 1024; mi++)
                    xmem[mk][mi] <= pat(mk, mi);
        end else begin
            if (pk_en) xmem[pk_k][pk_i] <= pk_v;
            for (int wk = 0; wk < 2; wk++) begin
                if (cs[wk] && we[wk]) begin
                    if (be[wk][0]) xmem[wk][xaddr[wk][9:0]][7:0]  <= xwd[wk][7:0];
                    if (be[wk][1]) xmem[wk][xaddr[wk][9:0]][15:8] <= xwd[wk][15:8];
                end
            end
        end
    end

    assign xrd[0] = xmem[0][xaddr[0][9:0]];
    assign xrd[1] = xmem[1][xaddr[1][9:0]];

    // Reference: plain little-endian byte memory, 2 KiB per instance.
    logic [7:0] refm [2][2048];

    int nchk = 0;
    int nerr = 0;

    logic [30:0] b0_a, bl_a;
    logic [1:0]  b0_be;
    logic [15:0] b0_wd, bl_wd;
    logic        b0_we;

    task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
        nchk++;
        if (act !== exp) begin
            nerr++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic poke(input int k, input int i, input logic [15:0] v);
        @(negedge clk);
        pk_en = 1'b1; pk_k = k; pk_i = i; pk_v = v;
        @(negedge clk);
        pk_en = 1'b0;
        refm[k][2*i]   = v[7:0];
        refm[k][2*i+1] = v[15:8];
    endtask

    task automatic ref_access(input int k, input logic w, input logic [1:0] sz, input logic [31:0] a,
                              input logic [31:0] wd, output logic [31:0] rd);
        int n, base, sh;
        logic [31:0] v;
        n = (sz == MB) ? 1 : (sz == MH) ? 2 : 4;
        base = int'(a % 2048);
        base = base - (base % n);
        v = '0;
        for (int i = 0; i < n; i++) begin
            if (w) refm[k][base+i] = wd[8*i +: 8];
            v = v | (32'(refm[k][base+i]) << (8*i));
        end
        sh = 8 * int'(a % 4);
        if (ROT && n == 4 && sh != 0) v = (v >> sh) | (v << (32 - sh));
        rd = w ? 32'h0 : v;
    endtask

    task automatic access(input int k, input logic w, input logic [1:0] sz, input logic [31:0] a,
                          input logic [31:0] wd, input bit drop,
                          output logic [31:0] rd, output int nst, output int ncs);
        @(negedge clk);
        en[k] = 1'b1; wr[k] = w; size[k] = sz; addr[k] = a; wdata[k] = wd;
        #1;
        nst = 0;
        ncs = 0;
        while (stall[k] && nst < 100) begin
            nst++;
            if (cs[k]) begin
                if (ncs == 0) begin
                    b0_a = xaddr[k]; b0_be = be[k]; b0_wd = xwd[k]; b0_we = we[k];
                end
                bl_a = xaddr[k]; bl_wd = xwd[k];
                ncs++;
            end
            @(negedge clk);
            if (drop) begin
                en[k] = 1'b0; wr[k] = ~w; size[k] = ~sz; addr[k] = ~a; wdata[k] = ~wd;
            end
            #1;
        end
        en[k] = 1'b0;
        rd = rdata[k];
    endtask

    typedef struct {
        int          k;
        logic        w;
        logic [1:0]  sz;
        logic [31:0] a;
        logic [31:0] wd;
        bit          drop;
        logic [31:0] rd;
        logic [30:0] a0;
        logic [30:0] al;
        logic [1:0]  be0;
        logic [15:0] wd0;
        logic [15:0] wdl;
        int          nst;
        int          ncs;
    } vec_t;

    vec_t tv [11];

    initial begin
        #900000;
        $display("FAIL watchdog: time limit reached before summary");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] rd, mr;
        int          ns, nc, k, ws;
        logic        w;
        logic [1:0]  sz;
        logic [31:0] a, wd;
        bit          drop;

        tv[0]  = '{1, 1'b0, MB,    32'h103,      32'h0,        1'b0, 32'h000000A5, 31'h81,       31'h81,       2'b10, 16'h0,    16'h0,    3, 2};
        tv[1]  = '{1, 1'b1, MW,    32'h200,      32'h12345678, 1'b0, 32'h0,        31'h100,      31'h101,      2'b11, 16'h5678, 16'h1234, 5, 4};
        tv[2]  = '{0, 1'b0, MW,    32'h40,       32'h0,        1'b0, 32'hDEADBEEF, 31'h20,       31'h21,       2'b11, 16'h0,    16'h0,    3, 2};
        tv[3]  = '{0, 1'b0, MW,    32'h41,       32'h0,        1'b0, ROT ? 32'hEFDEADBE : 32'hDEADBEEF,
                   31'h20, 31'h21, 2'b11, 16'h0, 16'h0, 3, 2};
        tv[4]  = '{1, 1'b1, MB,    32'h0,        32'hFFFFFF11, 1'b0, 32'h0,        31'h0,        31'h0,        2'b01, 16'h1111, 16'h1111, 3, 2};
        tv[5]  = '{1, 1'b0, MH,    32'h2,        32'h0,        1'b1, 32'h0000CAFE, 31'h1,        31'h1,        2'b11, 16'h0,    16'h0,    3, 2};
        tv[6]  = '{1, 1'b0, MB,    32'h1,        32'h0,        1'b0, 32'h00000077, 31'h0,        31'h0,        2'b10, 16'h0,    16'h0,    3, 2};
        tv[7]  = '{1, 1'b0, MB,    32'h0,        32'h0,        1'b0, 32'h00000011, 31'h0,        31'h0,        2'b01, 16'h0,    16'h0,    3, 2};
        tv[8]  = '{1, 1'b0, 2'b11, 32'hFFFFFFFC, 32'h0,        1'b0, 32'h44443333, 31'h7FFFFFFE, 31'h7FFFFFFF, 2'b11, 16'h0,    16'h0,    5, 4};
        tv[9]  = '{1, 1'b0, MH,    32'h203,      32'h0,        1'b0, 32'h00001234, 31'h101,      31'h101,      2'b11, 16'h0,    16'h0,    3, 2};
        tv[10] = '{1, 1'b1, MH,    32'h7,        32'hABCD9876, 1'b0, 32'h0,        31'h3,        31'h3,        2'b11, 16'h9876, 16'h9876, 3, 2};

        for (int rk = 0; rk < 2; rk++) begin
            for (int ri = 0; ri < 1024; ri++) begin
                refm[rk][2*ri]   = pat(rk, ri)[7:0];
                refm[rk][2*ri+1] = pat(rk, ri)[15:8];
            end
            en[rk] = 1'b0; wr[rk] = 1'b0; size[rk] = 2'b00; addr[rk] = '0; wdata[rk] = '0;
        end
        pk_en = 1'b0; pk_k = 0; pk_i = 0; pk_v = '0;
        rst = 1'b1;

        repeat (3) @(negedge clk);
        #1;
        for (int rk = 0; rk < 2; rk++) begin
            check($sformatf("rst%0d.cs", rk),    64'(cs[rk]),    64'h0);
            check($sformatf("rst%0d.we", rk),    64'(we[rk]),    64'h0);
            check($sformatf("rst%0d.be", rk),    64'(be[rk]),    64'h0);
            check($sformatf("rst%0d.addr", rk),  64'(xaddr[rk]), 64'h0);
            check($sformatf("rst%0d.wdata", rk), 64'(xwd[rk]),   64'h0);
            check($sformatf("rst%0d.rdata", rk), 64'(rdata[rk]), 64'h0);
            check($sformatf("rst%0d.stall", rk), 64'(stall[rk]), 64'h0);
        end
        @(negedge clk);
        rst = 1'b0;

        poke(1, 32'h81,  16'hA55A);
        poke(0, 32'h20,  16'hBEEF);
        poke(0, 32'h21,  16'hDEAD);
        poke(1, 0,       16'h7700);
        poke(1, 1,       16'hCAFE);
        poke(1, 32'h3FE, 16'h3333);
        poke(1, 32'h3FF, 16'h4444);

        for (int i = 0; i < 11; i++) begin
            ref_access(tv[i].k, tv[i].w, tv[i].sz, tv[i].a, tv[i].wd, mr);
            access(tv[i].k, tv[i].w, tv[i].sz, tv[i].a, tv[i].wd, tv[i].drop, rd, ns, nc);
            check($sformatf("tv%0d.stall_cycles", i), 64'(ns),    64'(tv[i].nst));
            check($sformatf("tv%0d.cs_cycles", i),    64'(nc),    64'(tv[i].ncs));
            check($sformatf("tv%0d.addr0", i),        64'(b0_a),  64'(tv[i].a0));
            check($sformatf("tv%0d.addr_last", i),    64'(bl_a),  64'(tv[i].al));
            check($sformatf("tv%0d.be0", i),          64'(b0_be), 64'(tv[i].be0));
            check($sformatf("tv%0d.we", i),           64'(b0_we), 64'(tv[i].w));
            if (tv[i].w) begin
                check($sformatf("tv%0d.wdata0", i),    64'(b0_wd), 64'(tv[i].wd0));
                check($sformatf("tv%0d.wdata_last", i), 64'(bl_wd), 64'(tv[i].wdl));
            end else begin
                check($sformatf("tv%0d.rdata", i),     64'(rd),    64'(tv[i].rd));
            end
        end

        // A write leaves the last read value in place, including the cycle after DONE.
        check("hold.done", 64'(rdata[1]), 64'h1234);
        @(negedge clk);
        #1;
        check("hold.next", 64'(rdata[1]), 64'h1234);

        for (int n = 0; n < 300; n++) begin
            k    = int'($urandom_range(0, 1));
            w    = 1'($urandom_range(0, 1));
            sz   = 2'($urandom_range(0, 3));
            a    = $urandom;
            wd   = $urandom;
            drop = ($urandom_range(0, 3) == 0);
            ws   = (k == 0) ? 0 : 1;
            ref_access(k, w, sz, a, wd, mr);
            access(k, w, sz, a, wd, drop, rd, ns, nc);
            check($sformatf("rnd%0d.stall_cycles", n), 64'(ns), 64'(sz[1] ? 2*ws + 3 : ws + 2));
            check($sformatf("rnd%0d.cs_cycles", n),    64'(nc), 64'(sz[1] ? 2*ws + 2 : ws + 1));
            check($sformatf("rnd%0d.addr0", n), 64'(b0_a), 64'(31'((a >> 1) & (sz[1] ? 32'hFFFFFFFE : 32'hFFFFFFFF))));
            if (!w) check($sformatf("rnd%0d.rdata", n), 64'(rd), 64'(mr));
            repeat ($urandom_range(0, 2)) @(negedge clk);
        end

        // Abort a word write in its first beat.
        access(1, 1'b1, MB, 32'h20, 32'h5A, 1'b0, rd, ns, nc);
        access(1, 1'b0, MB, 32'h20, 32'h0,  1'b0, rd, ns, nc);
        check("pre_rst.rdata", 64'(rd), 64'h5A);
        @(negedge clk);
        en[1] = 1'b1; wr[1] = 1'b1; size[1] = MW; addr[1] = 32'h300; wdata[1] = 32'hCAFEF00D;
        @(negedge clk);
        #1;
        check("abort.cs_in_beat0", 64'(cs[1]), 64'h1);
        rst = 1'b1;
        en[1] = 1'b0;
        @(negedge clk);
        #1;
        check("abort.cs",    64'(cs[1]),    64'h0);
        check("abort.we",    64'(we[1]),    64'h0);
        check("abort.be",    64'(be[1]),    64'h0);
        check("abort.stall", 64'(stall[1]), 64'h0);
        check("abort.rdata", 64'(rdata[1]), 64'h0);
        en[1] = 1'b1; wr[1] = 1'b1; size[1] = MB; addr[1] = 32'h31; wdata[1] = 32'h66;
        #1;
        check("abort.idle_accepts", 64'(stall[1]), 64'h1);
        en[1] = 1'b0;
        rst = 1'b0;
        access(1, 1'b1, MB, 32'h31, 32'h66, 1'b0, rd, ns, nc);
        check("post_rst.wr_stall", 64'(ns),    64'h3);
        check("post_rst.wr_be",    64'(b0_be), 64'h2);
        access(1, 1'b0, MB, 32'h31, 32'h0, 1'b0, rd, ns, nc);
        check("post_rst.rdata",    64'(rd),    64'h66);

        $display("Result: errors=%0d of %0d checks", nerr, nchk);
        $finish;
    end

endmodule

// File: doc/ram_bridge16.md
Name: ram_bridge16

Overview:
- Memory-side stage directly downstream of the pipeline memory controller.
- Takes its single-cycle RAM request (en/wr/size/addr/wdata) and runs it on a 16-bit external SRAM-style bus with programmable wait states.
- Splits word accesses into two halfword beats and steers byte/halfword lanes.
- Stalls the pipeline until the access completes; returns read data LSB-aligned and zero-extended, so sign extension stays upstream.

Parameters:
WAIT_STATES, 1, extra cycles per external beat (0..15); each beat holds o_ext_cs for WAIT_STATES+1 cycles

Ports:
clk  input  1  clock, all logic on rising edge
rst  input  1  synchronous reset, active-high
i_ram_en  input  1  request present; upstream holds all request fields stable while o_ram_stall=1
i_ram_wr  input  1  1=write, 0=read
i_ram_size  input  2  MEM_B / MEM_H / MEM_W (def.v encodings); 2'b11 treated as MEM_W
i_ram_addr  input  32  byte address
i_ram_wdata  input  32  write data, LSB-aligned
o_ram_rdata  output  32  read data, registered, LSB-aligned, zero-extended
o_ram_stall  output  1  pipeline stall, combinational
o_ext_cs  output  1  external chip select, registered
o_ext_we  output  1  external write enable, registered, valid only with cs
o_ext_be  output  2  byte enables {hi,lo}, registered
o_ext_addr  output  31  halfword address (byte addr[31:1]), registered
o_ext_wdata  output  16  external write data, registered
i_ext_rdata  input  16  external read data, sampled on last cycle of each beat

Behaviour:
- Reset (rst=1 at clk edge): state=IDLE, wait counter=0, o_ext_cs=0, o_ext_we=0, o_ext_be=0, o_ext_addr=0, o_ext_wdata=0, o_ram_rdata=0. Reset mid-transaction aborts immediately; cs drops the next edge.
- FSM states: IDLE, BEAT0, BEAT1, DONE.
- IDLE + i_ram_en: latch wr/size/addr/wdata, load beat-0 bus fields, set cs=1, counter=WAIT_STATES, go to BEAT0.
- BEAT0/BEAT1: counter decrements each cycle. On counter==0, the beat ends:
  - Reads sample i_ext_rdata.
  - Word in BEAT0: go to BEAT1; addr+1 (halfword), beat-1 data/be loaded, cs stays 1, counter reloaded.
  - Otherwise: go to DONE, cs=0, we=0, be=0.
- DONE: always returns to IDLE next cycle.
- o_ram_stall = (state==IDLE & i_ram_en) | state==BEAT0 | state==BEAT1. It is low in DONE, so the pipeline advances exactly once per access.
- o_ram_rdata updates only at the final read beat and holds until the next read completes. It is therefore valid in DONE and in the following cycle, when the upstream controller consumes it.
- Request fields are latched at accept; changes or i_ram_en falling during BEATx are ignored, and the access always completes.
- Lane rules:
  - Byte: ext_addr=addr[31:1]; be = addr[0] ? 2'b10 : 2'b01; wdata = {wdata[7:0], wdata[7:0]}; rdata = {24'b0, addr[0] ? ext[15:8] : ext[7:0]}.
  - Half: addr[0] ignored; be=2'b11; wdata = wdata[15:0]; rdata = {16'b0, ext}.
  - Word: addr[1:0] ignored; beat0 at {addr[31:2],0} carries bits [15:0], beat1 at +1 halfword carries [31:16]; be=2'b11 both beats.
- Cycle counts from accept to DONE inclusive: byte/half = WAIT_STATES+3; word = 2*WAIT_STATES+4.
- Back-to-back: a new request presented in the cycle after DONE is accepted in IDLE with no bubble beyond DONE.
- Halfword address wraps modulo 2^31 on word beat1 (address 0xFFFFFFFC → beat1 0x7FFFFFFF).

Optional Feature:
- Macro: RAM_BRIDGE_ROTATE_EN.
- Defined: word reads with addr[1:0]≠0 return the aligned word rotated right by 8*addr[1:0] (ARMv4 LDR semantics). Writes and byte/half accesses are unchanged.
- Undefined: addr[1:0] ignored for words; no rotation logic is synthesized.

Test Plan:
- WAIT_STATES=1, byte read addr 0x103, ext_rdata=0xA55A:
  - ext_addr=0x81, be=2'b10, cs high 2 cycles, stall high 3 cycles.
  - o_ram_rdata=0x000000A5 from DONE onward.
- WAIT_STATES=1, word write addr 0x200, wdata 0x12345678:
  - beat0 ext_addr=0x100, wdata=0x5678; beat1 ext_addr=0x101, wdata=0x1234.
  - cs continuous for 4 cycles, we=1, stall 5 cycles.
- WAIT_STATES=0, word read addr 0x40, ext returns 0xBEEF then 0xDEAD → o_ram_rdata=0xDEADBEEF; total 4 cycles accept-to-DONE.
- Rotate: with RAM_BRIDGE_ROTATE_EN defined, word read addr 0x41, memory 0xDEADBEEF → 0xEFDEADBE. Without the macro → 0xDEADBEEF.
- Reset mid-access: assert rst during BEAT0 of a word write → next cycle cs=0, state=IDLE, stall=0, o_ram_rdata=0. A following byte write completes normally.
- Back-to-back: byte write 0x11 to addr 0x0, then immediately half read at addr 0x2:
  - second access accepted in the cycle after DONE with be=2'b11, ext_addr=0x1.
  - i_ram_en dropped mid-access still completes the beat.
